// File: rtl/axis_frame_len_if.sv
// AXI4-Stream bundle shared by the frame length policer's input and output.
interface ifc_axis #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_frame_len.sv
// Per-frame byte-length policer for AXI4-Stream.
// Counts bytes from tkeep, truncates frames exceeding max_len (cut beat gets
// tlast and tuser[0]), drops the remainder, and strobes each forwarded frame's
// length. Single output register stage.
// Optional macro AXIS_FRAME_LEN_STATS_EN enables stat_frames/stat_trunc counters.
module axis_frame_len #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ifc_axis.slave               s_axis_ifc,
  ifc_axis.master              m_axis_ifc,
  input  logic [LEN_WIDTH-1:0] max_len,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 frame_len_valid,
  output logic                 frame_trunc,
  output logic [31:0]          stat_frames,
  output logic [31:0]          stat_trunc
);

  typedef enum logic {S_PASS, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  lim_q, lim_d;
  logic                  first_q, first_d;

  logic                  m_tvalid_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic [KEEP_WIDTH-1:0] m_tkeep_q;
  logic                  m_tlast_q;
  logic [ID_WIDTH-1:0]   m_tid_q;
  logic [DEST_WIDTH-1:0] m_tdest_q;
  logic [USER_WIDTH-1:0] m_tuser_q;

  logic [LEN_WIDTH-1:0]  frame_len_q;
  logic                  frame_len_valid_q;
  logic                  frame_trunc_q;

  logic [KEEP_WIDTH-1:0] in_keep;
  logic [LEN_WIDTH:0]    beat_bytes;
  logic [LEN_WIDTH-1:0]  lim;
  logic [LEN_WIDTH:0]    sum;
  logic [LEN_WIDTH-1:0]  sat_sum;
  logic [31:0]           rem;
  logic                  lim_hit;

  logic                  s_ready;
  logic                  accept;
  logic                  load;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [USER_WIDTH-1:0] out_user;
  logic [LEN_WIDTH-1:0]  out_len;
  logic                  out_trunc;

  // Beat byte count and limit comparison against the running count.
  always_comb begin
    in_keep    = (KEEP_ENABLE != 0) ? s_axis_ifc.tkeep : '1;
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + (LEN_WIDTH+1)'(in_keep[i]);
    end
    // The limit is latched on the first beat; use max_len directly on that beat.
    lim     = first_q ? max_len : lim_q;
    sum     = {1'b0, cnt_q} + beat_bytes;
    sat_sum = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
    lim_hit = (lim != '0) && (sum >= {1'b0, lim});
    rem     = 32'({1'b0, lim} - {1'b0, cnt_q});
  end

  // Next-state, handshake and output-beat shaping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    first_d   = first_q;
    load      = 1'b0;
    s_ready   = (state_q == S_PASS) ? (m_axis_ifc.tready | ~m_tvalid_q) : 1'b1;
    accept    = s_axis_ifc.tvalid & s_ready;
    out_keep  = in_keep;
    out_last  = s_axis_ifc.tlast;
    out_user  = (USER_ENABLE != 0) ? s_axis_ifc.tuser : '0;
    out_len   = sat_sum;
    out_trunc = 1'b0;

    case (state_q)
      S_PASS: begin
        if (accept) begin
          load    = 1'b1;
          first_d = 1'b0;
          if (first_q) lim_d = max_len;
          if (lim_hit && !s_axis_ifc.tlast) begin
            // Cut beat: keep only the bytes still inside the limit.
            for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
              if (i >= rem) out_keep[i] = 1'b0;
            end
            out_last  = 1'b1;
            if (USER_ENABLE != 0) out_user[0] = 1'b1;
            out_len   = lim;
            out_trunc = 1'b1;
            cnt_d     = '0;
            state_d   = S_DROP;
          end else if (s_axis_ifc.tlast) begin
            cnt_d   = '0;
            first_d = 1'b1;
          end else begin
            cnt_d = sat_sum;
          end
        end
      end
      S_DROP: begin
        if (accept && s_axis_ifc.tlast) begin
          state_d = S_PASS;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = S_PASS;
    endcase
  end

  // Frame tracking state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_PASS;
      cnt_q   <= '0;
      lim_q   <= '0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      first_q <= first_d;
    end
  end

  // Output register stage and per-frame status strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid_q        <= 1'b0;
      m_tdata_q         <= '0;
      m_tkeep_q         <= '0;
      m_tlast_q         <= 1'b0;
      m_tid_q           <= '0;
      m_tdest_q         <= '0;
      m_tuser_q         <= '0;
      frame_len_q       <= '0;
      frame_len_valid_q <= 1'b0;
      frame_trunc_q     <= 1'b0;
    end else begin
      frame_len_valid_q <= load & out_last;
      if (load) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_ifc.tdata;
        m_tkeep_q  <= (KEEP_ENABLE != 0) ? out_keep : '1;
        m_tlast_q  <= out_last;
        m_tid_q    <= (ID_ENABLE != 0) ? s_axis_ifc.tid : '0;
        m_tdest_q  <= (DEST_ENABLE != 0) ? s_axis_ifc.tdest : '0;
        m_tuser_q  <= out_user;
        if (out_last) begin
          frame_len_q   <= out_len;
          frame_trunc_q <= out_trunc;
        end
      end else if (m_axis_ifc.tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign s_axis_ifc.tready = s_ready;
  assign m_axis_ifc.tvalid = m_tvalid_q;
  assign m_axis_ifc.tdata  = m_tdata_q;
  assign m_axis_ifc.tkeep  = m_tkeep_q;
  assign m_axis_ifc.tlast  = m_tlast_q;
  assign m_axis_ifc.tid    = m_tid_q;
  assign m_axis_ifc.tdest  = m_tdest_q;
  assign m_axis_ifc.tuser  = m_tuser_q;

  assign frame_len       = frame_len_q;
  assign frame_len_valid = frame_len_valid_q;
  assign frame_trunc     = frame_trunc_q;

`ifdef AXIS_FRAME_LEN_STATS_EN
  logic [31:0] stat_frames_q;
  logic [31:0] stat_trunc_q;

  // Free-running frame and truncation counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_frames_q <= '0;
      stat_trunc_q  <= '0;
    end else if (frame_len_valid_q) begin
      stat_frames_q <= stat_frames_q + 32'd1;
      if (frame_trunc_q) stat_trunc_q <= stat_trunc_q + 32'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_trunc  = stat_trunc_q;
`else
  assign stat_frames = '0;
  assign stat_trunc  = '0;
`endif

endmodule

// File: tb/tb_axis_frame_len.sv
// Scoreboard bench for axis_frame_len with directed frames.
module tb_axis_frame_len;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  typedef struct {
    logic [15:0] len;
    logic        tr;
  } stat_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] max_len;
  logic [15:0] frame_len;
  logic        frame_len_valid;
  logic        frame_trunc;
  logic [31:0] stat_frames;
  logic [31:0] stat_trunc;

  int total = 0;
  int bad   = 0;
  int mode  = 1; // 0: m_tready low, 1: high, 2: toggle

  beat_t exp_q[$];
  stat_t st_q[$];

  ifc_axis s_if ();
  ifc_axis m_if ();

  axis_frame_len dut (
    .clk             (clk),
    .rst             (rst_n),
    .s_axis_ifc      (s_if),
    .m_axis_ifc      (m_if),
    .max_len         (max_len),
    .frame_len       (frame_len),
    .frame_len_valid (frame_len_valid),
    .frame_trunc     (frame_trunc),
    .stat_frames     (stat_frames),
    .stat_trunc      (stat_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output-side ready pattern, updated 2ns after each rising edge.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (mode == 0)      m_if.tready = 1'b0;
      else if (mode == 1) m_if.tready = 1'b1;
      else                m_if.tready = ~m_if.tready;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat or status.
  logic        hold_v = 1'b0;
  beat_t       hold_b;
  always @(negedge clk) begin
    beat_t e;
    stat_t s;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && m_if.tvalid) begin
        total++;
        if (m_if.tdata !== hold_b.d || m_if.tkeep !== hold_b.k ||
            m_if.tlast !== hold_b.l || m_if.tuser[0] !== hold_b.u) begin
          bad++;
          $display("FAIL stall_stable: got d=%h k=%b l=%b u=%b, want d=%h k=%b l=%b u=%b",
                   m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser[0],
                   hold_b.d, hold_b.k, hold_b.l, hold_b.u);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got d=%h k=%b l=%b, want no beat",
                   m_if.tdata, m_if.tkeep, m_if.tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_if.tdata !== e.d || m_if.tkeep !== e.k ||
              m_if.tlast !== e.l || m_if.tuser[0] !== e.u) begin
            bad++;
            $display("FAIL beat: got d=%h k=%b l=%b u=%b, want d=%h k=%b l=%b u=%b",
                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser[0],
                     e.d, e.k, e.l, e.u);
          end
        end
      end
      hold_v   = m_if.tvalid && !m_if.tready;
      hold_b.d = m_if.tdata;
      hold_b.k = m_if.tkeep;
      hold_b.l = m_if.tlast;
      hold_b.u = m_if.tuser[0];
      if (frame_len_valid) begin
        total++;
        if (st_q.size() == 0) begin
          bad++;
          $display("FAIL status_unexpected: got len=%0d tr=%b, want no status",
                   frame_len, frame_trunc);
        end else begin
          s = st_q.pop_front();
          if (frame_len !== s.len || frame_trunc !== s.tr) begin
            bad++;
            $display("FAIL status: got len=%0d tr=%b, want len=%0d tr=%b",
                     frame_len, frame_trunc, s.len, s.tr);
          end
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic push_st(input logic [15:0] len, input logic tr);
    stat_t s;
    s.len = len; s.tr = tr;
    st_q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Presents one beat and waits (bounded) for acceptance; reports whether
  // it was accepted on the first cycle presented.
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      output logic first_ready);
    logic acc;
    acc = 1'b0;
    first_ready = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = s_if.tready;
      if (n == 0) first_ready = acc;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept for d=%h, want accept", d);
    end
  endtask

  initial begin
    logic fr;
    rst_n       = 1'b0;
    max_len     = 16'd0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;

    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata", m_if.tdata, 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_len_valid", 32'(frame_len_valid), 32'd0);
    check("rst_frame_trunc", 32'(frame_trunc), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2-beat frame under limit 10.
    max_len = 16'd10;
    push_beat(32'hA000_0001, 4'b1111, 1'b0, 1'b0);
    push_beat(32'hA000_0002, 4'b1111, 1'b1, 1'b0);
    push_st(16'd8, 1'b0);
    send(32'hA000_0001, 4'b1111, 1'b0, fr);
    send(32'hA000_0002, 4'b1111, 1'b1, fr);

    // 4-beat frame truncated at 10 bytes, then an intact frame.
    push_beat(32'hB000_0001, 4'b1111, 1'b0, 1'b0);
    push_beat(32'hB000_0002, 4'b1111, 1'b0, 1'b0);
    push_beat(32'hB000_0003, 4'b0011, 1'b1, 1'b1);
    push_st(16'd10, 1'b1);
    push_beat(32'hB100_0001, 4'b1111, 1'b0, 1'b0);
    push_beat(32'hB100_0002, 4'b1111, 1'b1, 1'b0);
    push_st(16'd8, 1'b0);
    send(32'hB000_0001, 4'b1111, 1'b0, fr);
    send(32'hB000_0002, 4'b1111, 1'b0, fr);
    send(32'hB000_0003, 4'b1111, 1'b0, fr);
    send(32'hB000_0004, 4'b1111, 1'b1, fr);
    send(32'hB100_0001, 4'b1111, 1'b0, fr);
    send(32'hB100_0002, 4'b1111, 1'b1, fr);

    // Limit 8 hit exactly on a non-last beat; the third beat is dropped.
    max_len = 16'd8;
    push_beat(32'hC000_0001, 4'b1111, 1'b0, 1'b0);
    push_beat(32'hC000_0002, 4'b1111, 1'b1, 1'b1);
    push_st(16'd8, 1'b1);
    send(32'hC000_0001, 4'b1111, 1'b0, fr);
    send(32'hC000_0002, 4'b1111, 1'b0, fr);
    mode = 0;
    send(32'hC000_0003, 4'b1111, 1'b1, fr);
    check("drop_ready", 32'(fr), 32'd1);
    mode = 1;
    repeat (3) @(posedge clk);
    #1;

    // Unlimited, single 1-byte beat: output one cycle after acceptance.
    max_len = 16'd0;
    push_beat(32'hD000_0001, 4'b0001, 1'b1, 1'b0);
    push_st(16'd1, 1'b0);
    send(32'hD000_0001, 4'b0001, 1'b1, fr);
    check("lat_m_tvalid", 32'(m_if.tvalid), 32'd1);
    check("lat_m_tdata", m_if.tdata, 32'hD000_0001);
    check("lat_len_valid", 32'(frame_len_valid), 32'd1);

    // Three 3-beat frames with alternating m_tready.
    mode = 2;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 3; b++) begin
        push_beat(32'hE000_0000 + 32'(f * 16 + b), 4'b1111, (b == 2), 1'b0);
      end
      push_st(16'd12, 1'b0);
    end
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 3; b++) begin
        send(32'hE000_0000 + 32'(f * 16 + b), 4'b1111, (b == 2), fr);
      end
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    mode = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset asserted while dropping, with a held output beat.
    max_len = 16'd4;
    push_beat(32'hF000_0001, 4'b1111, 1'b1, 1'b1);
    push_st(16'd4, 1'b1);
    send(32'hF000_0001, 4'b1111, 1'b0, fr);
    mode = 0;
    send(32'hF000_0002, 4'b1111, 1'b0, fr);
    check("drop_ready2", 32'(fr), 32'd1);
    check("pre_rst_m_tvalid", 32'(m_if.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_len_valid", 32'(frame_len_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 1;
    @(posedge clk); #1;
    max_len = 16'd10;
    push_beat(32'h1000_0001, 4'b1111, 1'b0, 1'b0);
    push_beat(32'h1000_0002, 4'b1111, 1'b1, 1'b0);
    push_st(16'd8, 1'b0);
    send(32'h1000_0001, 4'b1111, 1'b0, fr);
    send(32'h1000_0002, 4'b1111, 1'b1, fr);

    for (int n = 0; n < 500 && (exp_q.size() != 0 || st_q.size() != 0); n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("status_left", 32'(st_q.size()), 32'd0);
`ifdef AXIS_FRAME_LEN_STATS_EN
    check("stat_frames", stat_frames, 32'd1);
    check("stat_trunc", stat_trunc, 32'd0);
`else
    check("stat_frames", stat_frames, 32'd0);
    check("stat_trunc", stat_trunc, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "timeout");
  end

endmodule
